// File: rtl/dma_rd_ar_arbiter.sv
// dma_rd_ar_arbiter: round-robin share of one AXI read port (AR + R) among NUM_REQ read engines
//  Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   req_arvalid/araddr/arlen/arready per-requester AR channel (flattened, requester i at slice i)
//   m_arvalid/araddr/arlen/arready   downstream AR channel, driven from a one-entry slot
//   m_rvalid/rdata/rlast/rready      downstream R channel (single ID, in-order)
//   req_rvalid/rdata/rlast/rready    R channel steered to the requester at the route FIFO head
//   outst_cnt                        bursts issued and not yet completed
//   err_unexp_rsp                    sticky flag: R beat arrived with no burst outstanding
module dma_rd_ar_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_W    = 64,
   parameter int LEN_W     = 8,
   parameter int DATA_W    = 512,
   parameter int MAX_OUTST = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_arvalid,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_araddr,
   input  logic [NUM_REQ*LEN_W-1:0]      req_arlen,
   output logic [NUM_REQ-1:0]            req_arready,
   output logic                          m_arvalid,
   output logic [ADDR_W-1:0]             m_araddr,
   output logic [LEN_W-1:0]              m_arlen,
   input  logic                          m_arready,
   input  logic                          m_rvalid,
   input  logic [DATA_W-1:0]             m_rdata,
   input  logic                          m_rlast,
   output logic                          m_rready,
   output logic [NUM_REQ-1:0]            req_rvalid,
   output logic [DATA_W-1:0]             req_rdata,
   output logic                          req_rlast,
   input  logic [NUM_REQ-1:0]            req_rready,
   output logic [$clog2(MAX_OUTST):0]    outst_cnt,
   output logic                          err_unexp_rsp
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int PW  = $clog2(MAX_OUTST);
   localparam int CW  = PW + 1;
   typedef enum logic {EMPTY, FULL} state_e;
   state_e                           state_q, state_d;
   logic [ADDR_W-1:0]                addr_q, addr_d;
   logic [LEN_W-1:0]                 len_q, len_d;
   logic [IDW-1:0]                   last_q, last_d;
   logic [PW-1:0]                    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]                    cnt_q, cnt_d;
   logic                             err_q, err_d;
   logic [IDW-1:0]                   mem_q [MAX_OUTST];
   logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_a;
   logic [NUM_REQ-1:0][LEN_W-1:0]    len_a;
   logic [IDW-1:0]                   idx, gnt_id, head;
   logic                             gnt_any, fifo_empty, fifo_full, load, pop;
   assign addr_a     = req_araddr;
   assign len_a      = req_arlen;
   assign fifo_empty = cnt_q == '0;
   assign fifo_full  = cnt_q == CW'(MAX_OUTST);
   assign head       = mem_q[rptr_q];
   // Search starts just after the previous winner so every requester gets a turn.
   always_comb begin
      idx     = '0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDW'((int'(last_q) + k) % NUM_REQ);
         if (!gnt_any && req_arvalid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
   end
   // The slot frees up when downstream accepts it, so reload happens the same cycle.
   assign load        = (state_q == EMPTY || m_arready) && !fifo_full && gnt_any;
   assign req_arready = load ? NUM_REQ'(1) << gnt_id : '0;
   assign m_rready    = req_rready[head] && !fifo_empty;
   assign req_rvalid  = (m_rvalid && !fifo_empty) ? NUM_REQ'(1) << head : '0;
   assign req_rdata   = m_rdata;
   assign req_rlast   = m_rlast;
   assign pop         = m_rvalid && m_rready && m_rlast;
   assign outst_cnt   = cnt_q;
   assign err_unexp_rsp = err_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         addr_q  <= '0;
         len_q   <= '0;
         last_q  <= IDW'(NUM_REQ - 1);
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         last_q  <= last_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (load) mem_q[wptr_q] <= gnt_id;
   end
   always_comb begin
      state_d = load ? FULL : (state_q == FULL && m_arready) ? EMPTY : state_q;
      addr_d  = load ? addr_a[gnt_id] : addr_q;
      len_d   = load ? len_a[gnt_id] : len_q;
      last_d  = load ? gnt_id : last_q;
      wptr_d  = load ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
      cnt_d   = cnt_q + CW'(load) - CW'(pop);
      err_d   = err_q || (m_rvalid && fifo_empty);
   end
   always_comb begin
      m_arvalid = state_q == FULL;
      m_araddr  = addr_q;
      m_arlen   = len_q;
   end
endmodule

// File: tb/tb_dma_rd_ar_arbiter.sv
// tb_dma_rd_ar_arbiter: directed scenarios plus random traffic against a queue-based reference model
//  The model tracks the pending AR request, the queue of burst owners and the sticky error flag,
//  and is compared with every DUT output on each falling edge.
module tb_dma_rd_ar_arbiter;
   localparam int N  = 2;
   localparam int AW = 64;
   localparam int LW = 8;
   localparam int DW = 64;
   localparam int MO = 8;
   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [N-1:0]      req_arvalid = '0;
   logic [N*AW-1:0]   req_araddr = '0;
   logic [N*LW-1:0]   req_arlen = '0;
   logic [N-1:0]      req_arready;
   logic              m_arvalid;
   logic [AW-1:0]     m_araddr;
   logic [LW-1:0]     m_arlen;
   logic              m_arready = 1'b0;
   logic              m_rvalid = 1'b0;
   logic [DW-1:0]     m_rdata = '0;
   logic              m_rlast = 1'b0;
   logic              m_rready;
   logic [N-1:0]      req_rvalid;
   logic [DW-1:0]     req_rdata;
   logic              req_rlast;
   logic [N-1:0]      req_rready = '0;
   logic [3:0]        outst_cnt;
   logic              err_unexp_rsp;
   int n_cmp = 0;
   int n_bad = 0;
   dma_rd_ar_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arready(req_arready),
      .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rready(m_rready),
      .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_rlast(req_rlast), .req_rready(req_rready),
      .outst_cnt(outst_cnt), .err_unexp_rsp(err_unexp_rsp)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask
   // Reference model state
   int         m_last;
   bit         m_sv;
   logic [63:0] m_sa;
   logic [7:0] m_sl;
   int         rq[$];
   bit         m_err;
   int         g, h, e_arr, e_rv;
   bit         ld, e_rr;
   always @(negedge clk) begin
      if (!reset_n) begin
         m_last = N - 1;
         m_sv   = 0;
         rq.delete();
         m_err  = 0;
         chk("rst_arvalid", 64'(m_arvalid), 0);
         chk("rst_araddr", m_araddr, 0);
         chk("rst_arlen", 64'(m_arlen), 0);
         chk("rst_outst", 64'(outst_cnt), 0);
         chk("rst_err", 64'(err_unexp_rsp), 0);
      end else begin
         g = -1;
         for (int k = 1; k <= N; k++)
            if (g < 0 && req_arvalid[(m_last + k) % N]) g = (m_last + k) % N;
         ld    = (!m_sv || m_arready) && rq.size() < MO && g >= 0;
         e_arr = ld ? (1 << g) : 0;
         h     = rq.size() > 0 ? rq[0] : -1;
         e_rr  = h >= 0 && req_rready[h];
         e_rv  = (h >= 0 && m_rvalid) ? (1 << h) : 0;
         chk("arready", 64'(req_arready), 64'(e_arr));
         chk("arvalid", 64'(m_arvalid), 64'(m_sv));
         if (m_sv) begin
            chk("araddr", m_araddr, m_sa);
            chk("arlen", 64'(m_arlen), 64'(m_sl));
         end
         chk("rvalid", 64'(req_rvalid), 64'(e_rv));
         chk("rready", 64'(m_rready), 64'(e_rr));
         chk("rdata", req_rdata, m_rdata);
         chk("rlast", 64'(req_rlast), 64'(m_rlast));
         chk("outst", 64'(outst_cnt), 64'(rq.size()));
         chk("err", 64'(err_unexp_rsp), 64'(m_err));
         if (m_rvalid && h < 0) m_err = 1;
         if (m_rvalid && e_rr && m_rlast) void'(rq.pop_front());
         if (ld) begin
            m_sv   = 1;
            m_sa   = req_araddr[g*AW +: AW];
            m_sl   = req_arlen[g*LW +: LW];
            m_last = g;
            rq.push_back(g);
         end else if (m_sv && m_arready) m_sv = 0;
      end
   end
   task automatic idle();
      req_arvalid = '0;
      m_arready   = 1'b0;
      m_rvalid    = 1'b0;
      m_rlast     = 1'b0;
      req_rready  = '0;
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      nxt();
      reset_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before t=200000");
      $fatal(1);
   end
   initial begin
      // T1 single burst of 4 beats
      do_reset();
      req_arvalid = 2'b01;
      req_araddr[0 +: AW] = 64'h1000;
      req_arlen[0 +: LW]  = 8'd3;
      @(negedge clk);
      chk("t1_arready", 64'(req_arready), 64'h1);
      nxt();
      req_arvalid = '0;
      m_arready = 1'b1;
      @(negedge clk);
      chk("t1_arvalid", 64'(m_arvalid), 1);
      chk("t1_araddr", m_araddr, 64'h1000);
      chk("t1_arlen", 64'(m_arlen), 3);
      chk("t1_outst1", 64'(outst_cnt), 1);
      nxt();
      m_arready = 1'b0;
      m_rvalid = 1'b1;
      req_rready = 2'b01;
      for (int b = 0; b < 4; b++) begin
         m_rlast = (b == 3);
         m_rdata = 64'(b + 16);
         @(negedge clk);
         chk("t1_rvalid", 64'(req_rvalid), 64'h1);
         chk("t1_rready", 64'(m_rready), 1);
         nxt();
      end
      idle();
      @(negedge clk);
      chk("t1_outst0", 64'(outst_cnt), 0);
      chk("t1_arvalid0", 64'(m_arvalid), 0);
      // T2 fairness
      do_reset();
      req_arvalid = 2'b11;
      req_araddr[0 +: AW] = 64'hA000;
      req_araddr[AW +: AW] = 64'hB000;
      m_arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_grant", 64'(req_arready), (i % 2) ? 64'h2 : 64'h1);
         chk("t2_arvalid", 64'(m_arvalid), (i > 0) ? 64'h1 : 64'h0);
         if (i > 0) chk("t2_araddr", m_araddr, ((i - 1) % 2) ? 64'hB000 : 64'hA000);
         nxt();
      end
      // T3 downstream stall
      do_reset();
      req_arvalid = 2'b01;
      req_araddr[0 +: AW] = 64'h3000;
      nxt();
      req_araddr[0 +: AW] = 64'h3100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_addr_hold", m_araddr, 64'h3000);
         chk("t3_arready0", 64'(req_arready), 0);
         nxt();
      end
      m_arready = 1'b1;
      @(negedge clk);
      chk("t3_release_grant", 64'(req_arready), 64'h1);
      nxt();
      req_arvalid = '0;
      @(negedge clk);
      chk("t3_new_addr", m_araddr, 64'h3100);
      // T4 route FIFO full
      do_reset();
      req_arvalid = 2'b01;
      m_arready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t4_fill", 64'(req_arready), 64'h1);
         nxt();
      end
      @(negedge clk);
      chk("t4_full_block", 64'(req_arready), 0);
      chk("t4_full_cnt", 64'(outst_cnt), 8);
      nxt();
      m_rvalid = 1'b1;
      m_rlast = 1'b1;
      req_rready = 2'b01;
      @(negedge clk);
      chk("t4_pop_block", 64'(req_arready), 0);
      chk("t4_pop_rready", 64'(m_rready), 1);
      nxt();
      m_rvalid = 1'b0;
      @(negedge clk);
      chk("t4_after_pop_cnt", 64'(outst_cnt), 7);
      chk("t4_after_pop_grant", 64'(req_arready), 64'h1);
      nxt();
      req_arvalid = '0;
      @(negedge clk);
      chk("t4_refill_cnt", 64'(outst_cnt), 8);
      // T5 interleaved R
      do_reset();
      req_arvalid = 2'b10;
      req_arlen[LW +: LW] = 8'd1;
      req_arlen[0 +: LW] = 8'd0;
      m_arready = 1'b1;
      nxt();
      req_arvalid = 2'b01;
      nxt();
      req_arvalid = '0;
      m_rvalid = 1'b1;
      m_rlast = 1'b0;
      req_rready = 2'b01;
      @(negedge clk);
      chk("t5_stall_rready", 64'(m_rready), 0);
      chk("t5_stall_rvalid", 64'(req_rvalid), 64'h2);
      nxt();
      req_rready = 2'b10;
      @(negedge clk);
      chk("t5_beat1", 64'(req_rvalid), 64'h2);
      chk("t5_beat1_rready", 64'(m_rready), 1);
      nxt();
      m_rlast = 1'b1;
      @(negedge clk);
      chk("t5_beat2", 64'(req_rvalid), 64'h2);
      nxt();
      req_rready = 2'b11;
      @(negedge clk);
      chk("t5_beat3", 64'(req_rvalid), 64'h1);
      nxt();
      idle();
      @(negedge clk);
      chk("t5_done", 64'(outst_cnt), 0);
      // T6 unexpected response, then async reset mid-burst
      do_reset();
      m_rvalid = 1'b1;
      req_rready = 2'b11;
      @(negedge clk);
      chk("t6_rready0", 64'(m_rready), 0);
      chk("t6_rvalid0", 64'(req_rvalid), 0);
      nxt();
      m_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_err_sticky", 64'(err_unexp_rsp), 1);
         nxt();
      end
      req_arvalid = 2'b01;
      req_araddr[0 +: AW] = 64'h6000;
      nxt();
      req_arvalid = '0;
      m_rvalid = 1'b1;
      m_rlast = 1'b0;
      req_rready = 2'b01;
      nxt();
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_ar_rst", 64'(m_arvalid), 0);
      chk("t6_addr_rst", m_araddr, 0);
      chk("t6_cnt_rst", 64'(outst_cnt), 0);
      chk("t6_err_rst", 64'(err_unexp_rsp), 0);
      chk("t6_rvalid_rst", 64'(req_rvalid), 0);
      chk("t6_rready_rst", 64'(m_rready), 0);
      idle();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      // Random traffic, with periodic resets
      for (int c = 0; c < 4000; c++) begin
         if (c % 700 == 699) begin
            reset_n = 1'b0;
            nxt();
            nxt();
            reset_n = 1'b1;
         end
         req_arvalid = N'($urandom_range(0, 3));
         for (int i = 0; i < N; i++) begin
            req_araddr[i*AW +: AW] = {$urandom, $urandom};
            req_arlen[i*LW +: LW]  = LW'($urandom);
         end
         m_arready  = $urandom_range(0, 2) != 0;
         m_rvalid   = $urandom_range(0, 1) != 0;
         m_rlast    = $urandom_range(0, 2) == 0;
         m_rdata    = {$urandom, $urandom};
         req_rready = N'($urandom_range(0, 3)) | N'($urandom_range(0, 3));
         nxt();
      end
      idle();
      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
